// File: rtl/ser_to_par_n_if.sv
// Word-side and serial-side signal bundle for ser_to_par_n.
// slave = deserialiser view, master = driver/consumer view.
interface ser_to_par_n_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = $clog2(WIDTH + 1)
);
    logic             ser_in;
    logic             ser_valid;
    logic             frame_start;
    logic [WIDTH-1:0] par_out;
    logic             par_valid;
    logic             par_ready;
    logic             overrun;
    logic             clr_ovr;
    logic [CNT_W-1:0] bit_count;
    logic             par_err;

    modport slave (
        input  ser_in, ser_valid, frame_start, par_ready, clr_ovr,
        output par_out, par_valid, overrun, bit_count, par_err
    );

    modport master (
        output ser_in, ser_valid, frame_start, par_ready, clr_ovr,
        input  par_out, par_valid, overrun, bit_count, par_err
    );
endinterface

// File: rtl/ser_to_par_n.sv
// Parametrised serial-to-parallel deserialiser with valid/ready output and sticky overrun.
// Define SER2PAR_PARITY_EN to expect an even-parity bit after each word (drives par_err).
module ser_to_par_n #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned MSB_FIRST = 0,
    parameter int unsigned CNT_W     = $clog2(WIDTH + 1)
) (
    input logic           clk,
    input logic           reset,
    ser_to_par_n_if.slave bus
);

`ifdef SER2PAR_PARITY_EN
    localparam bit PARITY_EN = 1'b1;
`else
    localparam bit PARITY_EN = 1'b0;
`endif
    localparam int unsigned BPW = PARITY_EN ? WIDTH + 1 : WIDTH;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic             pacc_q, pacc_d;
    logic             pend_q, pend_d;
    logic [WIDTH-1:0] pend_word_q, pend_word_d;
    logic             pend_err_q, pend_err_d;
    logic [WIDTH-1:0] out_q;
    logic             valid_q;
    logic             ovr_q;
    logic             perr_q;

    logic [CNT_W-1:0] cnt_base;
    logic [WIDTH-1:0] sh_base;
    logic [WIDTH-1:0] sh_bit;
    logic             pacc_base;
    int unsigned      bit_idx;

    // frame_start restarts the word before the current bit is placed
    always_comb begin
        cnt_base    = bus.frame_start ? '0 : cnt_q;
        sh_base     = bus.frame_start ? '0 : sh_q;
        pacc_base   = bus.frame_start ? 1'b0 : pacc_q;
        bit_idx     = (MSB_FIRST != 0) ? (WIDTH - 1 - 32'(cnt_base)) : 32'(cnt_base);
        sh_bit      = (cnt_base < CNT_W'(WIDTH)) ? (WIDTH'(bus.ser_in) << bit_idx) : '0;
        cnt_d       = cnt_base;
        sh_d        = sh_base;
        pacc_d      = pacc_base;
        pend_d      = 1'b0;
        pend_word_d = pend_word_q;
        pend_err_d  = pend_err_q;
        if (bus.ser_valid) begin
            if (cnt_base == CNT_W'(BPW - 1)) begin
                pend_d      = 1'b1;
                pend_word_d = sh_base | sh_bit;
                pend_err_d  = pacc_base ^ bus.ser_in;
                cnt_d       = '0;
                sh_d        = '0;
                pacc_d      = 1'b0;
            end else begin
                cnt_d  = cnt_base + CNT_W'(1);
                sh_d   = sh_base | sh_bit;
                pacc_d = pacc_base ^ bus.ser_in;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q       <= '0;
            sh_q        <= '0;
            pacc_q      <= 1'b0;
            pend_q      <= 1'b0;
            pend_word_q <= '0;
            pend_err_q  <= 1'b0;
            out_q       <= '0;
            valid_q     <= 1'b0;
            ovr_q       <= 1'b0;
            perr_q      <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            sh_q        <= sh_d;
            pacc_q      <= pacc_d;
            pend_q      <= pend_d;
            pend_word_q <= pend_word_d;
            pend_err_q  <= pend_err_d;
            // completed word lands one edge after its last bit, if the slot is free or being drained
            if (pend_q && (!valid_q || bus.par_ready)) begin
                out_q   <= pend_word_q;
                perr_q  <= pend_err_q;
                valid_q <= 1'b1;
            end else if (valid_q && bus.par_ready) begin
                valid_q <= 1'b0;
            end
            if (pend_q && valid_q && !bus.par_ready) begin
                ovr_q <= 1'b1;
            end else if (bus.clr_ovr) begin
                ovr_q <= 1'b0;
            end
        end
    end

    assign bus.par_out   = out_q;
    assign bus.par_valid = valid_q;
    assign bus.overrun   = ovr_q;
    assign bus.bit_count = cnt_q;
    assign bus.par_err   = PARITY_EN & perr_q;

endmodule

// File: tb/tb_ser_to_par_n.sv
// Bench for ser_to_par_n: LSB-first and MSB-first instances share stimulus; a queue-based
// reference model predicts words, handshake and overrun; a negedge monitor checks output words.
module tb_ser_to_par_n;

`ifdef SER2PAR_PARITY_EN
    localparam int BPW = 9;
`else
    localparam int BPW = 8;
`endif

    typedef struct {
        logic [7:0] lsb;
        logic [7:0] msb;
        logic       err;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n, ser_in, ser_valid, frame_start, par_ready, clr_ovr;
    int   total = 0;
    int   bad   = 0;
    bit   mon_en = 0;

    exp_t exp_q[$];
    bit   mbits[$];
    bit   mpend, mslot, movr;
    exp_t mpend_w;

    always #5 clk = ~clk;

    ser_to_par_n_if #(.WIDTH(8)) if_lsb ();
    ser_to_par_n_if #(.WIDTH(8)) if_msb ();

    assign if_lsb.ser_in      = ser_in;
    assign if_lsb.ser_valid   = ser_valid;
    assign if_lsb.frame_start = frame_start;
    assign if_lsb.par_ready   = par_ready;
    assign if_lsb.clr_ovr     = clr_ovr;
    assign if_msb.ser_in      = ser_in;
    assign if_msb.ser_valid   = ser_valid;
    assign if_msb.frame_start = frame_start;
    assign if_msb.par_ready   = par_ready;
    assign if_msb.clr_ovr     = clr_ovr;

    ser_to_par_n #(.WIDTH(8), .MSB_FIRST(0)) u_lsb (.clk(clk), .reset(rst_n), .bus(if_lsb));
    ser_to_par_n #(.WIDTH(8), .MSB_FIRST(1)) u_msb (.clk(clk), .reset(rst_n), .bus(if_msb));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a word is the list of accepted bits since the last restart.
    task automatic step(input logic sv, input logic si, input logic fs,
                        input logic rdy, input logic clr, input logic rst);
        bit   set_ovr;
        exp_t w;
        ser_valid   = sv;
        ser_in      = si;
        frame_start = fs;
        par_ready   = rdy;
        clr_ovr     = clr;
        rst_n       = rst;
        @(posedge clk);
        set_ovr = 0;
        if (!rst) begin
            mbits.delete();
            exp_q.delete();
            mpend = 0;
            mslot = 0;
            movr  = 0;
        end else begin
            if (mpend) begin
                if (!mslot || rdy) begin
                    mslot = 1;
                    exp_q.push_back(mpend_w);
                end else begin
                    set_ovr = 1;
                end
            end else if (mslot && rdy) begin
                mslot = 0;
            end
            if (set_ovr) movr = 1;
            else if (clr) movr = 0;
            mpend = 0;
            if (fs) mbits.delete();
            if (sv) mbits.push_back(si);
            if (mbits.size() == BPW) begin
                w.lsb = '0;
                w.msb = '0;
                w.err = 1'b0;
                for (int i = 0; i < 8; i++) begin
                    w.lsb = w.lsb + (8'(mbits[i]) << i);
                    w.msb = w.msb + (8'(mbits[i]) << (7 - i));
                end
`ifdef SER2PAR_PARITY_EN
                foreach (mbits[i]) w.err = w.err ^ mbits[i];
`endif
                mpend_w = w;
                mpend   = 1;
                mbits.delete();
            end
        end
        #1;
        chk("valid_lsb", 64'(if_lsb.par_valid), 64'(mslot));
        chk("valid_msb", 64'(if_msb.par_valid), 64'(mslot));
        chk("ovr_lsb", 64'(if_lsb.overrun), 64'(movr));
        chk("ovr_msb", 64'(if_msb.overrun), 64'(movr));
        chk("cnt_lsb", 64'(if_lsb.bit_count), 64'(mbits.size()));
        chk("cnt_msb", 64'(if_msb.bit_count), 64'(mbits.size()));
    endtask

    task automatic idle(input logic rdy);
        step(1'b0, 1'b0, 1'b0, rdy, 1'b0, 1'b1);
    endtask

    task automatic send_word(input logic [7:0] v, input logic rdy, input int gap, input logic par);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, v[i], 1'b0, rdy, 1'b0, 1'b1);
            if (i < 7) repeat (gap) idle(rdy);
        end
`ifdef SER2PAR_PARITY_EN
        step(1'b1, par, 1'b0, rdy, 1'b0, 1'b1);
`else
        if (par) idle(rdy);
`endif
    endtask

    // Monitor: every presented word must match the oldest predicted one; pop on transfer.
    always @(negedge clk) begin
        if (mon_en && if_lsb.par_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL word_unexpected: got %0h expected none", if_lsb.par_out);
            end else begin
                chk("word_lsb", 64'(if_lsb.par_out), 64'(exp_q[0].lsb));
                chk("word_msb", 64'(if_msb.par_out), 64'(exp_q[0].msb));
                chk("err_lsb", 64'(if_lsb.par_err), 64'(exp_q[0].err));
                chk("err_msb", 64'(if_msb.par_err), 64'(exp_q[0].err));
                if (par_ready) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        mpend = 0;
        mslot = 0;
        movr  = 0;
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        mon_en = 1;
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("rst_out_lsb", 64'(if_lsb.par_out), 64'h0);
        chk("rst_out_msb", 64'(if_msb.par_out), 64'h0);
        chk("rst_err", 64'(if_lsb.par_err), 64'h0);

        // basic word, continuous ser_valid, consumer always ready
        send_word(8'h4D, 1'b1, 0, 1'b0);
        idle(1'b1);
        chk("w1_lsb", 64'(if_lsb.par_out), 64'h4D);
        chk("w1_msb", 64'(if_msb.par_out), 64'hB2);
        idle(1'b1);

        // ser_valid toggling: completion on the 15th bit-cycle
        send_word(8'h4D, 1'b1, 1, 1'b0);
        idle(1'b1);
        idle(1'b1);

        // overrun: second word dropped while first unconsumed
        send_word(8'h4D, 1'b0, 0, 1'b0);
        idle(1'b0);
        send_word(8'hFF, 1'b0, 0, 1'b0);
        idle(1'b0);
        chk("ovr_keep_word", 64'(if_lsb.par_out), 64'h4D);
        chk("ovr_set", 64'(if_lsb.overrun), 64'h1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("ovr_clr", 64'(if_lsb.overrun), 64'h0);
        idle(1'b1);

        // completion coinciding with a transfer: no overrun
        send_word(8'h4D, 1'b0, 0, 1'b0);
        idle(1'b0);
        send_word(8'hFF, 1'b0, 0, 1'b0);
        idle(1'b1);
        chk("swap_word", 64'(if_lsb.par_out), 64'hFF);
        chk("swap_ovr", 64'(if_lsb.overrun), 64'h0);
        idle(1'b1);

        // frame_start resync with a bit
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        chk("fs_cnt", 64'(if_lsb.bit_count), 64'h1);
        begin
            logic [7:0] v;
            v = 8'hA5;
            for (int i = 1; i < 8; i++) step(1'b1, v[i], 1'b0, 1'b1, 1'b0, 1'b1);
`ifdef SER2PAR_PARITY_EN
            step(1'b1, ^v, 1'b0, 1'b1, 1'b0, 1'b1);
`endif
        end
        idle(1'b1);
        chk("fs_word", 64'(if_lsb.par_out), 64'hA5);
        idle(1'b1);

        // reset mid-word
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("mid_rst_out", 64'(if_lsb.par_out), 64'h0);
        chk("mid_rst_cnt", 64'(if_lsb.bit_count), 64'h0);
        send_word(8'h3C, 1'b1, 0, 1'b0);
        idle(1'b1);
        chk("post_rst_word", 64'(if_lsb.par_out), 64'h3C);
        idle(1'b1);

`ifdef SER2PAR_PARITY_EN
        send_word(8'h4D, 1'b1, 0, 1'b0);
        idle(1'b1);
        chk("par_ok", 64'(if_lsb.par_err), 64'h0);
        send_word(8'h4D, 1'b1, 0, 1'b1);
        idle(1'b1);
        chk("par_bad", 64'(if_lsb.par_err), 64'h1);
        idle(1'b1);
`endif

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            step(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom_range(0, 40) == 0),
                 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 20) == 0),
                 1'($urandom_range(0, 300) != 0));
        end
        repeat (4) idle(1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
